// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one UART TX byte stream among
// NUM_INPUTS AXI-Stream producers, with an optional per-packet channel header.

module uart_tx_arbiter_lane (
  input  logic       sel,
  input  logic       tvalid,
  input  logic [7:0] tdata,
  input  logic       tlast,
  input  logic       m_tready,
  output logic       tready,
  output logic       vld_m,
  output logic [7:0] data_m,
  output logic       last_m
);
  // Masked contributions so the top can OR-reduce instead of muxing.
  assign tready = sel & m_tready;
  assign vld_m  = sel & tvalid;
  assign data_m = sel ? tdata : 8'h00;
  assign last_m = sel & tlast;
endmodule

module uart_tx_arbiter #(
  parameter int         NUM_INPUTS       = 4,
  parameter int         HEADER_ENABLE    = 1,
  parameter logic [7:0] HEADER_BASE      = 8'hF0,
  parameter int         MAX_PACKET_BYTES = 256,
  localparam int        IW               = $clog2(NUM_INPUTS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_INPUTS-1:0]   s_tvalid,
  input  logic [8*NUM_INPUTS-1:0] s_tdata,
  input  logic [NUM_INPUTS-1:0]   s_tlast,
  output logic [NUM_INPUTS-1:0]   s_tready,
  output logic                    m_tvalid,
  output logic [7:0]              m_tdata,
  input  logic                    m_tready,
  output logic                    grant_valid,
  output logic [IW-1:0]           grant_index
);
  typedef enum logic [1:0] {ARB_IDLE, ARB_HEADER, ARB_DATA} arb_state_t;

  arb_state_t state, state_nxt;
  logic [IW-1:0] last_grant;
  logic [15:0]   beat_count;

  logic [NUM_INPUTS-1:0]        lane_sel, lane_vld, lane_last;
  logic [NUM_INPUTS-1:0][7:0]   lane_data;
  logic                         sel_vld, sel_last;
  logic [7:0]                   sel_data;
  logic                         pick_found;
  logic [IW-1:0]                pick_idx, cand;
  logic                         beat_acc, pkt_end;

  for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_lane
    assign lane_sel[g] = (state == ARB_DATA) && (grant_index == IW'(g));
    uart_tx_arbiter_lane u_lane (
      .sel      (lane_sel[g]),
      .tvalid   (s_tvalid[g]),
      .tdata    (s_tdata[8*g +: 8]),
      .tlast    (s_tlast[g]),
      .m_tready (m_tready),
      .tready   (s_tready[g]),
      .vld_m    (lane_vld[g]),
      .data_m   (lane_data[g]),
      .last_m   (lane_last[g])
    );
  end

  always_comb begin
    sel_data = 8'h00;
    for (int i = 0; i < NUM_INPUTS; i++) sel_data = sel_data | lane_data[i];
  end
  assign sel_vld  = |lane_vld;
  assign sel_last = |lane_last;

  // First requester at or after last_grant+1, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      cand = IW'((int'(last_grant) + 1 + i) % NUM_INPUTS);
      if (!pick_found && s_tvalid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign beat_acc    = (state == ARB_DATA) && sel_vld && m_tready;
  assign pkt_end     = beat_acc && (sel_last || beat_count == 16'(MAX_PACKET_BYTES - 1));
  assign grant_valid = (state != ARB_IDLE);

  always_comb begin
    state_nxt = state;
    m_tvalid  = 1'b0;
    m_tdata   = 8'h00;
    case (state)
      ARB_IDLE: begin
        if (pick_found) state_nxt = (HEADER_ENABLE != 0) ? ARB_HEADER : ARB_DATA;
      end
      ARB_HEADER: begin
        m_tvalid = 1'b1;
        m_tdata  = HEADER_BASE + 8'(grant_index);
        if (m_tready) state_nxt = ARB_DATA;
      end
      ARB_DATA: begin
        m_tvalid = sel_vld;
        m_tdata  = sel_vld ? sel_data : 8'h00;
        if (pkt_end) state_nxt = ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ARB_IDLE;
      last_grant  <= IW'(NUM_INPUTS - 1);
      grant_index <= '0;
      beat_count  <= '0;
    end else begin
      state <= state_nxt;
      if (state == ARB_IDLE && pick_found) begin
        grant_index <= pick_idx;
        beat_count  <= '0;
      end
      if (beat_acc) beat_count <= beat_count + 16'd1;
      if (pkt_end)  last_grant <= grant_index;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: per-cycle vector table plus queued
// producer sequences for fairness, forced release, backpressure and reset.

module tb_uart_tx_arbiter;
  localparam int N = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [N-1:0]     s_tvalid = '0, s_tlast = '0, s_tready;
  logic [8*N-1:0]   s_tdata = '0;
  logic             m_tvalid, m_tready = 1'b0;
  logic [7:0]       m_tdata;
  logic             grant_valid;
  logic [1:0]       grant_index;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_INPUTS(N), .HEADER_ENABLE(1), .HEADER_BASE(8'hF0), .MAX_PACKET_BYTES(4)
  ) dut (
    .clk(clk), .reset(reset),
    .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tready(m_tready),
    .grant_valid(grant_valid), .grant_index(grant_index)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic [3:0]  tv;
    logic [31:0] td;
    logic [3:0]  tl;
    logic        mr;
    logic        e_mv;
    logic [7:0]  e_md;
    logic [3:0]  e_sr;
    logic        e_gv;
    logic [1:0]  e_gi;
  } vec_t;

  vec_t vecs[15];

  // Producer model: per-input FIFO of {last, byte}.
  logic [8:0]  pmem[N][16];
  int          head[N], tail[N];
  logic [7:0]  olog[$];
  int          glog[$];

  task automatic push(input int i, input logic [7:0] d, input logic l);
    pmem[i][tail[i]] = {l, d};
    tail[i]++;
  endtask

  task automatic clear_q();
    for (int i = 0; i < N; i++) begin head[i] = 0; tail[i] = 0; end
    olog.delete();
    glog.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    s_tvalid = '0; s_tlast = '0; s_tdata = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    clear_q();
  endtask

  task automatic run_auto(input int ncyc, input int stop_after, input logic [3:0] pat);
    logic       prev_gv, prev_stall;
    logic [7:0] prev_d;
    logic [N-1:0] pop;
    prev_gv = 1'b0; prev_stall = 1'b0; prev_d = 8'h00;
    for (int c = 0; c < ncyc; c++) begin
      for (int i = 0; i < N; i++) begin
        s_tvalid[i]      = (head[i] < tail[i]);
        s_tdata[8*i +: 8] = s_tvalid[i] ? pmem[i][head[i]][7:0] : 8'h00;
        s_tlast[i]       = s_tvalid[i] ? pmem[i][head[i]][8] : 1'b0;
      end
      m_tready = pat[c % 4];
      @(negedge clk);
      if (!m_tvalid) chk("idle_data_zero", 32'(m_tdata), 32'h0);
      if (prev_stall) begin
        chk("stall_valid", 32'(m_tvalid), 32'h1);
        chk("stall_data", 32'(m_tdata), 32'(prev_d));
      end
      if (grant_valid) chk("foreign_ready", 32'(s_tready & ~(4'b0001 << grant_index)), 32'h0);
      if (s_tready != '0) chk("ready_mirror", 32'(m_tready), 32'h1);
      if (m_tvalid && m_tready) olog.push_back(m_tdata);
      if (grant_valid && !prev_gv) glog.push_back(int'(grant_index));
      pop        = s_tvalid & s_tready;
      prev_gv    = grant_valid;
      prev_stall = m_tvalid && !m_tready;
      prev_d     = m_tdata;
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) if (pop[i]) head[i]++;
      if (stop_after != 0 && olog.size() >= stop_after) break;
    end
  endtask

  task automatic chk_log(input string name, input logic [7:0] exp[$]);
    chk({name, "_len"}, 32'(olog.size()), 32'(exp.size()));
    for (int k = 0; k < exp.size() && k < olog.size(); k++)
      chk(name, 32'(olog[k]), 32'(exp[k]));
  endtask

  initial begin
    logic [7:0] exp[$];
    // rst tv td tl mr | mv md sr gv gi
    vecs[0]  = '{1'b1, 4'b0000, 32'h0000_0000, 4'b0000, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0};
    vecs[1]  = '{1'b0, 4'b0100, 32'h0011_0000, 4'b0000, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0};
    vecs[2]  = '{1'b0, 4'b0100, 32'h0011_0000, 4'b0000, 1'b1, 1'b1, 8'hF2, 4'b0000, 1'b1, 2'd2};
    vecs[3]  = '{1'b0, 4'b0100, 32'h0011_0000, 4'b0000, 1'b1, 1'b1, 8'h11, 4'b0100, 1'b1, 2'd2};
    vecs[4]  = '{1'b0, 4'b0100, 32'h0022_0000, 4'b0000, 1'b1, 1'b1, 8'h22, 4'b0100, 1'b1, 2'd2};
    vecs[5]  = '{1'b0, 4'b0100, 32'h0033_0000, 4'b0100, 1'b1, 1'b1, 8'h33, 4'b0100, 1'b1, 2'd2};
    vecs[6]  = '{1'b0, 4'b0000, 32'h0000_0000, 4'b0000, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd2};
    vecs[7]  = '{1'b1, 4'b0000, 32'h0000_0000, 4'b0000, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0};
    vecs[8]  = '{1'b0, 4'b1010, 32'hA300_A100, 4'b1010, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0};
    vecs[9]  = '{1'b0, 4'b1010, 32'hA300_A100, 4'b1010, 1'b1, 1'b1, 8'hF1, 4'b0000, 1'b1, 2'd1};
    vecs[10] = '{1'b0, 4'b1010, 32'hA300_A100, 4'b1010, 1'b1, 1'b1, 8'hA1, 4'b0010, 1'b1, 2'd1};
    vecs[11] = '{1'b0, 4'b1000, 32'hA300_0000, 4'b1000, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd1};
    vecs[12] = '{1'b0, 4'b1000, 32'hA300_0000, 4'b1000, 1'b1, 1'b1, 8'hF3, 4'b0000, 1'b1, 2'd3};
    vecs[13] = '{1'b0, 4'b1000, 32'hA300_0000, 4'b1000, 1'b1, 1'b1, 8'hA3, 4'b1000, 1'b1, 2'd3};
    vecs[14] = '{1'b0, 4'b0000, 32'h0000_0000, 4'b0000, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd3};

    clear_q();
    @(posedge clk); #1;
    foreach (vecs[v]) begin
      reset    = vecs[v].rst;
      s_tvalid = vecs[v].tv;
      s_tdata  = vecs[v].td;
      s_tlast  = vecs[v].tl;
      m_tready = vecs[v].mr;
      @(negedge clk);
      chk($sformatf("v%0d_m_tvalid", v),    32'(m_tvalid),    32'(vecs[v].e_mv));
      chk($sformatf("v%0d_m_tdata", v),     32'(m_tdata),     32'(vecs[v].e_md));
      chk($sformatf("v%0d_s_tready", v),    32'(s_tready),    32'(vecs[v].e_sr));
      chk($sformatf("v%0d_grant_valid", v), 32'(grant_valid), 32'(vecs[v].e_gv));
      chk($sformatf("v%0d_grant_index", v), 32'(grant_index), 32'(vecs[v].e_gi));
      @(posedge clk); #1;
    end

    // Fairness: four inputs, three 2-byte packets each, all pending at once.
    do_reset();
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < N; i++) begin
        push(i, 8'((i << 4) | (2*p)), 1'b0);
        push(i, 8'((i << 4) | (2*p + 1)), 1'b1);
      end
    run_auto(60, 0, 4'b1111);
    exp.delete();
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < N; i++) begin
        exp.push_back(8'(8'hF0 + i));
        exp.push_back(8'((i << 4) | (2*p)));
        exp.push_back(8'((i << 4) | (2*p + 1)));
      end
    chk_log("fair_bytes", exp);
    chk("fair_grants_len", 32'(glog.size()), 32'd12);
    for (int k = 0; k < 12 && k < glog.size(); k++) chk("fair_grant_order", 32'(glog[k]), 32'(k % 4));

    // Forced release after 4 beats without tlast.
    do_reset();
    for (int b = 1; b <= 6; b++) push(0, 8'(b), b == 6);
    run_auto(20, 0, 4'b1111);
    exp = '{8'hF0, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF0, 8'h05, 8'h06};
    chk_log("force_bytes", exp);
    chk("force_grants", 32'(glog.size()), 32'd2);
    if (glog.size() == 2) chk("force_second_idx", 32'(glog[1]), 32'd0);

    // Backpressure: ready pattern 1,0,0,1 across header and data.
    do_reset();
    push(1, 8'h51, 1'b0); push(1, 8'h52, 1'b0); push(1, 8'h53, 1'b1);
    run_auto(20, 0, 4'b1001);
    exp = '{8'hF1, 8'h51, 8'h52, 8'h53};
    chk_log("bp_bytes", exp);
    chk("bp_drained", 32'(head[1]), 32'd3);

    // Reset mid-packet: input 0 finishes a packet, then input 2 is cut off.
    do_reset();
    push(0, 8'h0A, 1'b1);
    for (int b = 0; b < 5; b++) push(2, 8'(8'h20 + b), b == 4);
    run_auto(20, 5, 4'b1111);
    chk("rst_pre_grant", 32'(grant_index), 32'd2);
    reset = 1'b1;
    #1;
    chk("rst_m_tvalid", 32'(m_tvalid), 32'h0);
    chk("rst_m_tdata", 32'(m_tdata), 32'h0);
    chk("rst_s_tready", 32'(s_tready), 32'h0);
    chk("rst_grant_valid", 32'(grant_valid), 32'h0);
    chk("rst_grant_index", 32'(grant_index), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    clear_q();
    push(0, 8'h0B, 1'b1);
    push(2, 8'h2B, 1'b1);
    run_auto(20, 0, 4'b1111);
    exp = '{8'hF0, 8'h0B, 8'hF2, 8'h2B};
    chk_log("rst_after_bytes", exp);
    if (glog.size() > 0) chk("rst_first_winner", 32'(glog[0]), 32'd0);
    else chk("rst_first_winner_seen", 32'(glog.size()), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

- Round-robin, packet-locked arbiter that shares one UART transmitter among `NUM_INPUTS` AXI-Stream byte producers.
- Sits in front of the UART `tx_stream` sink. Once an input is granted, it owns the link until its `tlast` beat or until a maximum packet length is reached.
- Optionally sends a one-byte channel header before each packet so the far end can demultiplex.

## Interface

**Parameters**

- `NUM_INPUTS`, default 4: number of requesting streams, 2..16.
- `HEADER_ENABLE`, default 1: when 1, emit header byte `HEADER_BASE + index` before each packet.
- `HEADER_BASE`, default 8'hF0: header byte value for input 0.
- `MAX_PACKET_BYTES`, default 256: grant is forcibly released after this many data beats without `tlast`; range 1..65535.

**Ports**

- `clk` input 1: single clock; all logic is on its rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `s_tvalid` input `NUM_INPUTS`: per-input valid.
- `s_tdata` input `8*NUM_INPUTS`: per-input byte; input i occupies bits [8i+7:8i].
- `s_tlast` input `NUM_INPUTS`: per-input end of packet.
- `s_tready` output `NUM_INPUTS`: per-input ready.
- `m_tvalid` output 1: valid to the UART TX stream.
- `m_tdata` output 8: byte to the UART TX stream.
- `m_tready` input 1: ready from the UART TX stream.
- `grant_valid` output 1: high while a packet is owned (HEADER or DATA state).
- `grant_index` output `$clog2(NUM_INPUTS)`: currently or most recently granted input.

## Operation

**State machine: `ARB_IDLE`, `ARB_HEADER`, `ARB_DATA`.**

- **`ARB_IDLE`**
  - `m_tvalid`=0 and all `s_tready`=0.
  - If any `s_tvalid` is set, select the first asserted input scanning from `(last_grant+1) mod NUM_INPUTS` upward with wrap.
  - Register the selection into `grant_index`, clear `beat_count`.
  - Go to `ARB_HEADER` if `HEADER_ENABLE`, else `ARB_DATA`.
- **`ARB_HEADER`**
  - `m_tvalid`=1, `m_tdata`=`HEADER_BASE + grant_index` (8-bit wrap), all `s_tready`=0.
  - On `m_tvalid && m_tready`, go to `ARB_DATA`.
- **`ARB_DATA`** (combinational pass-through of the granted input g)
  - `m_tvalid`=`s_tvalid[g]`, `m_tdata`=`s_tdata[g]`, `s_tready[g]`=`m_tready`; every other `s_tready`=0.
  - Each accepted beat increments `beat_count` (16-bit).
  - Leave when the accepted beat has `s_tlast`=1, or when `beat_count` == `MAX_PACKET_BYTES-1` (forced release).
  - On leaving: `last_grant`<=g, go to `ARB_IDLE`.
- `s_tvalid[g]` deasserting mid-packet does not release the grant; the arbiter waits indefinitely.
- `m_tdata` is 8'h00 whenever `m_tvalid`=0.
- Inputs that are not granted see `s_tready`=0 and must hold their data (AXIS rules).

## Timing

**Reset values:** state=`ARB_IDLE`, `last_grant`=`NUM_INPUTS-1` (input 0 has first priority), `grant_index`=0, `grant_valid`=0, `beat_count`=0, `m_tvalid`=0, `s_tready`=0.

- **Arbitration latency:** 1 cycle. A request seen in `ARB_IDLE` on edge N gives `grant_valid`=1 and the header (or first data beat) on `m_tvalid` in cycle N+1.
- **Packet gap:** one idle cycle (`ARB_IDLE`) between consecutive packets, even from the same input.
- **Data path:** zero added latency in `ARB_DATA`; the `m_tready`→`s_tready` path is combinational.
- **Simultaneous requests:** resolved purely by round-robin order; a request arriving during a grant waits.
- **Forced release:** the grant is dropped even if `s_tlast`=0. The remainder of that packet is re-arbitrated as a new packet and gets a new header.
- **Reset mid-packet:** everything returns to reset values immediately (asynchronously); the partial packet is truncated with no `tlast` marker downstream.
- **Backpressure:** `m_tready`=0 holds `m_tvalid`/`m_tdata` stable in both `ARB_HEADER` and `ARB_DATA`.

## Test plan

1. **Single packet, header on.** Input 2 sends 8'h11, 8'h22, 8'h33(last), `m_tready`=1.
   - Output: 8'hF2, 8'h11, 8'h22, 8'h33.
   - `grant_valid` high for 4 cycles, starting 1 cycle after the request.
2. **Simultaneous requests.** After reset, inputs 1 and 3 each request a 1-byte packet together.
   - Input 1 is served first, then input 3, with one idle cycle between.
   - Output: F1, data1, F3, data3.
3. **Fairness.** All 4 inputs request continuously with 2-byte packets for 12 packets.
   - Grant order is 0,1,2,3 repeated 3 times; no input is starved.
4. **Forced release.** Set `MAX_PACKET_BYTES`=4; input 0 streams 6 bytes with `tlast` only on the 6th.
   - Output: F0, b1–b4, then a second grant F0, b5, b6; `grant_valid` drops between the two.
5. **Backpressure.** `m_tready` toggles 1,0,0,1 during the header and data phases.
   - No byte is lost or duplicated; `m_tdata` is stable while stalled; `s_tready[g]` mirrors `m_tready`.
6. **Reset mid-packet.** Assert `reset` after the 2nd data beat of a 5-byte packet.
   - Outputs go to their reset values in the same cycle.
   - After release, input 0 wins first when inputs 0 and 2 both request.
